chunked_ripple_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 20 ++
 rtl/chunk_add.sv | 35 +++
 rtl/chunked_ripple_adder.sv | 114 +++++++++++
 tb/tb_chunked_ripple_adder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the chunked ripple adder.
// The OVF feature of chunked_ripple_adder is enabled by defining ADDER_OVF_EN.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns 0 for an illegal WIDTH/CHUNK pairing so the top can refuse to elaborate.
  function automatic int nchunk(input int width, input int chunk);
    if (chunk < 1 || chunk > width || (width % chunk) != 0) return 0;
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple adder slice, reused once per RUN cycle.
// With ADDER_OVF_EN defined it also exposes the carry into its MSB.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
`ifdef ADDER_OVF_EN
  ,
  output logic             cmsb
`endif
);

  logic [CHUNK:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co = c[CHUNK];

`ifdef ADDER_OVF_EN
  assign cmsb = c[CHUNK-1];
`endif

endmodule

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle WIDTH-bit adder that ripples CHUNK bits per clock with a registered carry.
// Define ADDER_OVF_EN to add the signed-overflow output OVF.
module chunked_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             CO
`ifdef ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if (NCHUNK == 0) begin : g_bad_cfg
    $error("chunked_ripple_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
`ifdef ADDER_OVF_EN
  logic             msb_carry;
`endif

  // Operands shift right so the active chunk always sits in the low bits.
  chunk_add #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a   (a_sh[CHUNK-1:0]),
    .b   (b_sh[CHUNK-1:0]),
    .ci  (carry),
    .s   (s_chunk),
    .co  (c_chunk)
`ifdef ADDER_OVF_EN
    ,
    .cmsb(msb_carry)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      SUM       <= '0;
      CO        <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
`ifdef ADDER_OVF_EN
      OVF       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= A;
            b_sh     <= B;
            carry    <= CI;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          SUM[cnt*CHUNK +: CHUNK] <= s_chunk;
          carry <= c_chunk;
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          if (cnt == LAST) begin
            CO        <= c_chunk;
`ifdef ADDER_OVF_EN
            OVF       <= msb_carry ^ c_chunk;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Results stay frozen under backpressure; no new accept until the return completes.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Self-checking bench for chunked_ripple_adder: directed vectors, backpressure, reset abort
// and randomized sweeps on three WIDTH/CHUNK configurations.
module tb_chunked_ripple_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_in  [3];
  logic [15:0] b_in  [3];
  logic        ci_in [3];
  logic        iv    [3];
  logic        ordy  [3];

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        co0, co1, co2;
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [11:0] sum2;
`ifdef ADDER_OVF_EN
  logic        ovf0, ovf1, ovf2;
`endif

  int checks = 0;
  int errors = 0;

  chunked_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
    .A(a_in[0]), .B(b_in[0]), .CI(ci_in[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .SUM(sum0), .CO(co0)
`ifdef ADDER_OVF_EN
    , .OVF(ovf0)
`endif
  );

  chunked_ripple_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
    .A(a_in[1][7:0]), .B(b_in[1][7:0]), .CI(ci_in[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .SUM(sum1), .CO(co1)
`ifdef ADDER_OVF_EN
    , .OVF(ovf1)
`endif
  );

  chunked_ripple_adder #(.WIDTH(12), .CHUNK(12)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
    .A(a_in[2][11:0]), .B(b_in[2][11:0]), .CI(ci_in[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .SUM(sum2), .CO(co2)
`ifdef ADDER_OVF_EN
    , .OVF(ovf2)
`endif
  );

  function automatic logic [15:0] get_sum(input int k);
    case (k)
      0:       return sum0;
      1:       return {8'h00, sum1};
      default: return {4'h0, sum2};
    endcase
  endfunction

  function automatic logic get_co(input int k);
    case (k)
      0:       return co0;
      1:       return co1;
      default: return co2;
    endcase
  endfunction

  function automatic logic get_ov(input int k);
    case (k)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_ir(input int k);
    case (k)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

`ifdef ADDER_OVF_EN
  function automatic logic get_ovf(input int k);
    case (k)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf2;
    endcase
  endfunction
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction on the 16/4 instance; operand inputs are scrambled after accept.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output logic [15:0] s, output logic c, output logic v, output int lat);
    int n;
    n = 0;
    while (!ir0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_add", ir0, 1);
    a_in[0] = a; b_in[0] = b; ci_in[0] = ci; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    a_in[0] = 16'($urandom); b_in[0] = 16'($urandom); ci_in[0] = 1'($urandom);
    lat = 0;
    while (!ov0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum0;
    c = co0;
`ifdef ADDER_OVF_EN
    v = ovf0;
`else
    v = 1'b0;
`endif
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  // Random valid/ready traffic against an arithmetic reference and a FIFO scoreboard.
  task automatic run_random(input int k, input int w, input int nops);
    logic [15:0] q_sum [$];
    logic        q_co  [$];
    logic        q_ovf [$];
    logic [15:0] mask;
    logic [16:0] tot;
    logic [15:0] es;
    logic        acc;
    int sent, got, cyc;
    mask = 16'((32'h1 << w) - 1);
    sent = 0; got = 0; cyc = 0;
    iv[k] = 1'b0; ordy[k] = 1'b0;
    @(posedge clk); #1;
    while (got < nops && cyc < 30000) begin
      if (!iv[k] && sent < nops && $urandom_range(3) != 0) begin
        a_in[k]  = 16'($urandom) & mask;
        b_in[k]  = 16'($urandom) & mask;
        ci_in[k] = 1'($urandom);
        iv[k]    = 1'b1;
      end
      @(negedge clk);
      ordy[k] = ($urandom_range(3) != 0);
      acc = iv[k] && get_ir(k);
      if (acc) begin
        tot = {1'b0, a_in[k]} + {1'b0, b_in[k]} + {16'h0, ci_in[k]};
        es  = tot[15:0] & mask;
        q_sum.push_back(es);
        q_co.push_back(tot[w]);
        q_ovf.push_back((a_in[k][w-1] == b_in[k][w-1]) && (es[w-1] != a_in[k][w-1]));
        sent++;
      end
      if (get_ov(k) && ordy[k]) begin
        chk($sformatf("rand%0d_result_expected", k), q_sum.size() != 0, 1);
        if (q_sum.size() != 0) begin
          chk($sformatf("rand%0d_co_sum", k), {get_co(k), get_sum(k)}, {q_co[0], q_sum[0]});
`ifdef ADDER_OVF_EN
          chk($sformatf("rand%0d_ovf", k), get_ovf(k), q_ovf[0]);
`endif
          void'(q_sum.pop_front());
          void'(q_co.pop_front());
          void'(q_ovf.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        iv[k]    = 1'b0;
        a_in[k]  = 16'($urandom) & mask;
        b_in[k]  = 16'($urandom) & mask;
        ci_in[k] = 1'($urandom);
      end
      cyc++;
    end
    chk($sformatf("rand%0d_results_returned", k), got, nops);
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [15:0] s;
    logic        c, v;
    int          lat, n;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};

    for (int k = 0; k < 3; k++) begin
      a_in[k] = '0; b_in[k] = '0; ci_in[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir0, 0);
    chk("rst_out_valid", ov0, 0);
    chk("rst_sum", sum0, 16'h0000);
    chk("rst_co", co0, 0);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", ovf0, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", ir0, 1);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      do_add(vt[i].a, vt[i].b, vt[i].ci, s, c, v, lat);
      chk($sformatf("vec%0d_sum", i), s, vt[i].sum);
      chk($sformatf("vec%0d_co", i), c, vt[i].co);
      chk($sformatf("vec%0d_latency", i), lat, 4);
`ifdef ADDER_OVF_EN
      chk($sformatf("vec%0d_ovf", i), v, vt[i].ovf);
`endif
    end

    // Backpressure: results frozen, no accept while DONE
    n = 0;
    while (!ir0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    a_in[0] = 16'h0F0F; b_in[0] = 16'h1111; ci_in[0] = 1'b1; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n = 0;
    while (!ov0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", ov0, 1);
    a_in[0] = 16'hAAAA; b_in[0] = 16'h5555; ci_in[0] = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_sum", i), sum0, 16'h2021);
      chk($sformatf("bp%0d_co", i), co0, 0);
      chk($sformatf("bp%0d_in_ready", i), ir0, 0);
      chk($sformatf("bp%0d_out_valid", i), ov0, 1);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    iv[0] = 1'b0;
    chk("bp_out_valid_after_hs", ov0, 0);
    chk("bp_in_ready_after_hs", ir0, 1);
    @(posedge clk); #1;
    chk("bp_no_accept_in_done", ir0, 1);

    // Reset during the second RUN cycle
    a_in[0] = 16'h1234; b_in[0] = 16'h1111; ci_in[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", ov0, 0);
    chk("abort_sum", sum0, 16'h0000);
    chk("abort_co", co0, 0);
    chk("abort_in_ready", ir0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready_release", ir0, 1);
    do_add(16'h0F00, 16'h0100, 1'b0, s, c, v, lat);
    chk("post_abort_sum", s, 16'h1000);
    chk("post_abort_co", c, 0);
    chk("post_abort_latency", lat, 4);

    // Random sweeps
    run_random(0, 16, 1000);
    run_random(1, 8, 1000);
    run_random(2, 12, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
